// File: rtl/paddle_emulator.sv
// paddle_emulator: emulates two analog paddle potentiometers on the video
// timeline. Each paddle output is discharged at the vsync rise and charges
// high once the scanline count reaches that paddle's (slew-limited) position,
// so a reader latching the line number on the rising edge recovers the position.
module paddle_emulator #(
    parameter int POS_W = 8,
    parameter int SLEW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             enable,
    input  logic             pos_valid,
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] pos_y,
    output logic             hpaddle,
    output logic             vpaddle,
    output logic [POS_W-1:0] cur_x,
    output logic [POS_W-1:0] cur_y
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHARGE = 2'd1;
    localparam logic [1:0] ST_FIRED  = 2'd2;

    localparam logic [POS_W-1:0] LINE_MAX = '1;
    localparam logic [POS_W-1:0] LINE_ONE = POS_W'(1);
    localparam logic [POS_W:0]   SLEW_W   = (POS_W+1)'(SLEW);

    logic             r_hs_d;
    logic             r_vs_d;
    logic             w_hs_rise;
    logic             w_vs_rise;
    logic [POS_W-1:0] r_line;
    logic [POS_W-1:0] r_tgt_x;
    logic [POS_W-1:0] r_tgt_y;
    logic [POS_W-1:0] r_cur_x;
    logic [POS_W-1:0] r_cur_y;
    logic [POS_W-1:0] w_slew_x;
    logic [POS_W-1:0] w_slew_y;
    logic [POS_W-1:0] w_cur [2];
    logic [1:0]       r_state [2];
    logic [1:0]       r_pad;

    // Sync inputs already live in the clk domain, so only a one-cycle
    // history is needed for rising-edge detection.
    assign w_hs_rise = hsync & ~r_hs_d;
    assign w_vs_rise = vsync & ~r_vs_d;

    // One slew step: move toward the target by at most SLEW lines. One extra
    // bit of headroom keeps the comparisons free of wrap-around.
    function automatic logic [POS_W-1:0] slew_step(input logic [POS_W-1:0] cur,
                                                   input logic [POS_W-1:0] tgt);
        logic [POS_W:0] c_e;
        logic [POS_W:0] t_e;
        logic [POS_W:0] n_e;
        c_e = {1'b0, cur};
        t_e = {1'b0, tgt};
        if (t_e > c_e + SLEW_W) begin
            n_e = c_e + SLEW_W;
        end else if (c_e > t_e + SLEW_W) begin
            n_e = c_e - SLEW_W;
        end else begin
            n_e = t_e;
        end
        return n_e[POS_W-1:0];
    endfunction

    assign w_slew_x = slew_step(r_cur_x, r_tgt_x);
    assign w_slew_y = slew_step(r_cur_y, r_tgt_y);

    assign w_cur[0] = r_cur_x;
    assign w_cur[1] = r_cur_y;

    // Sync history and saturating scanline counter; vsync rise wins over hsync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_line <= '0;
        end else begin
            r_hs_d <= hsync;
            r_vs_d <= vsync;
            if (w_vs_rise) begin
                r_line <= '0;
            end else if (w_hs_rise && (r_line != LINE_MAX)) begin
                r_line <= r_line + LINE_ONE;
            end
        end
    end

    // Target load and once-per-frame slew; a load in the vsync-rise cycle is
    // stored but the slew of that cycle still sees the old target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tgt_x <= '0;
            r_tgt_y <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else begin
            if (pos_valid) begin
                r_tgt_x <= pos_x;
                r_tgt_y <= pos_y;
            end
            if (w_vs_rise) begin
                r_cur_x <= w_slew_x;
                r_cur_y <= w_slew_y;
            end
        end
    end

    // Per-channel IDLE/CHARGE/FIRED machine; index 0 drives hpaddle, 1 vpaddle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < 2; c++) begin
                r_state[c] <= ST_IDLE;
                r_pad[c]   <= 1'b0;
            end
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                if (!enable) begin
                    r_state[c] <= ST_IDLE;
                    r_pad[c]   <= 1'b0;
                end else begin
                    case (r_state[c])
                        ST_IDLE: begin
                            r_pad[c] <= 1'b0;
                            if (w_vs_rise) begin
                                r_state[c] <= ST_CHARGE;
                            end
                        end
                        ST_CHARGE: begin
                            // A new frame restarts the charge before any
                            // comparison against the stale line count.
                            if (w_vs_rise) begin
                                r_pad[c] <= 1'b0;
                            end else if (r_line >= w_cur[c]) begin
                                r_state[c] <= ST_FIRED;
                                r_pad[c]   <= 1'b1;
                            end
                        end
                        ST_FIRED: begin
                            if (w_vs_rise) begin
                                r_state[c] <= ST_CHARGE;
                                r_pad[c]   <= 1'b0;
                            end
                        end
                        default: begin
                            r_state[c] <= ST_IDLE;
                            r_pad[c]   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign hpaddle = r_pad[0];
    assign vpaddle = r_pad[1];
    assign cur_x   = r_cur_x;
    assign cur_y   = r_cur_y;

endmodule

// File: tb/tb_paddle_emulator.sv
// tb_paddle_emulator: drives synthetic video frames with directed and random
// position loads, enable drops and resets. A frame-level reference model
// pushes the expected outputs after every clock edge; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_paddle_emulator;

    localparam int POS_W = 8;
    localparam int SLEW  = 4;
    localparam int MAXL  = (1 << POS_W) - 1;

    logic             clk;
    logic             reset;
    logic             hsync;
    logic             vsync;
    logic             enable;
    logic             pos_valid;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             hpaddle;
    logic             vpaddle;
    logic [POS_W-1:0] cur_x;
    logic [POS_W-1:0] cur_y;

    paddle_emulator #(.POS_W(POS_W), .SLEW(SLEW)) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync     (hsync),
        .vsync     (vsync),
        .enable    (enable),
        .pos_valid (pos_valid),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .hpaddle   (hpaddle),
        .vpaddle   (vpaddle),
        .cur_x     (cur_x),
        .cur_y     (cur_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic h;
        logic v;
        int   cx;
        int   cy;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   rnd_mode = 1'b0;

    // Reference model: lines seen since the last vsync, whether each channel
    // has been armed by a vsync while enabled, and the slewed positions.
    int m_line;
    int m_cur [2];
    int m_tgt [2];
    bit m_armed [2];
    bit m_hd;
    bit m_vd;

    function automatic int slew(input int c, input int t);
        if (t - c > SLEW) return c + SLEW;
        if (c - t > SLEW) return c - SLEW;
        return t;
    endfunction

    function automatic void model_step();
        exp_t e;
        bit   vr;
        bit   hr;
        bit   o [2];
        int   px [2];
        if (reset) begin
            m_line = 0;
            m_hd   = 1'b0;
            m_vd   = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_cur[c]   = 0;
                m_tgt[c]   = 0;
                m_armed[c] = 1'b0;
                o[c]       = 1'b0;
            end
        end else begin
            vr    = vsync && !m_vd;
            hr    = hsync && !m_hd;
            px[0] = int'(pos_x);
            px[1] = int'(pos_y);
            for (int c = 0; c < 2; c++) begin
                // High once the frame's line count has reached the position,
                // and only within a frame that started while enabled.
                o[c] = enable && !vr && m_armed[c] && (m_line >= m_cur[c]);
                if (!enable) m_armed[c] = 1'b0;
                else if (vr) m_armed[c] = 1'b1;
                if (vr) m_cur[c] = slew(m_cur[c], m_tgt[c]);
                if (pos_valid) m_tgt[c] = px[c];
            end
            if (vr) m_line = 0;
            else if (hr && m_line < MAXL) m_line = m_line + 1;
            m_hd = hsync;
            m_vd = vsync;
        end
        e.h  = o[0];
        e.v  = o[1];
        e.cx = m_cur[0];
        e.cy = m_cur[1];
        q.push_back(e);
    endfunction

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Monitor: every clock has one expected output set; compare on the falling edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            total++;
            if ({hpaddle, vpaddle} !== {mon_e.h, mon_e.v}) begin
                bad++;
                $display("FAIL paddles @%0t: got h=%b v=%b expected h=%b v=%b",
                         $time, hpaddle, vpaddle, mon_e.h, mon_e.v);
            end
            total++;
            if (int'(cur_x) != mon_e.cx || int'(cur_y) != mon_e.cy) begin
                bad++;
                $display("FAIL positions @%0t: got x=%0d y=%0d expected x=%0d y=%0d",
                         $time, cur_x, cur_y, mon_e.cx, mon_e.cy);
            end
        end
    end

    task automatic cyc(input logic h, input logic v);
        hsync = h;
        vsync = v;
        @(posedge clk);
        model_step();
        #1;
        pos_valid = 1'b0;
    endtask

    task automatic rand_load();
        pos_valid = 1'b1;
        pos_x     = POS_W'($urandom_range(0, MAXL));
        pos_y     = POS_W'($urandom_range(0, MAXL));
    endtask

    // One frame: vsync (optionally with a coincident hsync rise and/or a
    // position load), then `lines` hsync pulses of three clocks each.
    task automatic frame(input int lines, input bit hs_vs, input bit pv_vs,
                         input int drop_at, input int raise_at);
        if (pv_vs) pos_valid = 1'b1;
        cyc(hs_vs, 1'b1);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < lines; i++) begin
            if (i == drop_at)  enable = 1'b0;
            if (i == raise_at) enable = 1'b1;
            if (rnd_mode && $urandom_range(0, 63) == 0) rand_load();
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic load(input int x, input int y);
        pos_valid = 1'b1;
        pos_x     = POS_W'(x);
        pos_y     = POS_W'(y);
        cyc(1'b0, 1'b0);
    endtask

    int slew_seq [6] = '{14, 18, 22, 26, 30, 30};

    initial begin
        reset     = 1'b1;
        hsync     = 1'b0;
        vsync     = 1'b0;
        enable    = 1'b1;
        pos_valid = 1'b0;
        pos_x     = '0;
        pos_y     = '0;
        #2;
        check("reset_hpaddle", int'(hpaddle), 0);
        check("reset_cur_y", int'(cur_y), 0);
        repeat (3) cyc(1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);

        // Steady positions 40 / 100 after settling.
        load(40, 100);
        repeat (26) frame(20, 1'b0, 1'b0, -1, -1);
        check("steady_cur_x", int'(cur_x), 40);
        check("steady_cur_y", int'(cur_y), 100);
        repeat (2) frame(120, 1'b0, 1'b0, -1, -1);

        // Slew from 10 toward 30 in steps of 4.
        load(10, 100);
        repeat (9) frame(20, 1'b0, 1'b0, -1, -1);
        check("slew_start_x", int'(cur_x), 10);
        load(30, 100);
        for (int k = 0; k < 6; k++) begin
            frame(40, 1'b0, 1'b0, -1, -1);
            check("slew_step_x", int'(cur_x), slew_seq[k]);
        end

        // Edge positions: 0 and 255, with long and short frames.
        load(0, 255);
        repeat (40) frame(20, 1'b0, 1'b0, -1, -1);
        check("edge_cur_y", int'(cur_y), 255);
        frame(262, 1'b0, 1'b0, -1, -1);
        check("edge_fired_255", int'(vpaddle), 1);
        frame(200, 1'b0, 1'b0, -1, -1);
        check("edge_short_frame", int'(vpaddle), 0);
        frame(262, 1'b0, 1'b0, -1, -1);

        // Coincident hsync/vsync rise, with a load in that same cycle.
        pos_x = POS_W'(20);
        pos_y = POS_W'(30);
        frame(50, 1'b1, 1'b1, -1, -1);
        frame(50, 1'b1, 1'b0, -1, -1);
        frame(50, 1'b0, 1'b0, -1, -1);

        // Enable dropped and raised mid-frame.
        frame(120, 1'b0, 1'b0, 50, 80);
        frame(120, 1'b0, 1'b0, -1, -1);

        // Reset while hpaddle is high.
        load(5, 8);
        repeat (10) frame(20, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        check("pre_reset_hpaddle", int'(hpaddle), 1);
        reset = 1'b1;
        #1;
        check("async_reset_hpaddle", int'(hpaddle), 0);
        check("async_reset_cur_x", int'(cur_x), 0);
        repeat (2) cyc(1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
        check("post_reset_idle", int'(hpaddle), 0);
        repeat (2) frame(30, 1'b0, 1'b0, -1, -1);

        // Randomized frames, loads and enable drops.
        rnd_mode = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int lines;
            int drop;
            int raise;
            lines = $urandom_range(20, 262);
            drop  = -1;
            raise = -1;
            if ($urandom_range(0, 3) == 0) begin
                drop  = $urandom_range(0, lines - 1);
                raise = drop + $urandom_range(1, 40);
            end
            frame(lines, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), drop, raise);
            enable = 1'b1;
        end
        rnd_mode = 1'b0;
        frame(30, 1'b0, 1'b0, -1, -1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddle_emulator.md
Name: paddle_emulator

Overview:
- Emulates two analog paddle potentiometers for the paddle-input video designs: converts digital X/Y positions into timed `hpaddle`/`vpaddle` pulses on the video timeline.
- Each frame, a paddle output is discharged (low) at vsync and goes high once the scanline count reaches that paddle's position. This reproduces RC-charge timing, so a paddle reader latching `vpos[7:0]` on the rising edge recovers the position.
- Sits beside the hvsync generator, which supplies its `hsync`/`vsync` in the same clock domain. Includes a per-frame slew limiter so a position cannot jump.

Parameters:
- POS_W, 8, width of positions and of the line counter.
- SLEW, 4, maximum change of the active position per frame, in lines; must be ≥ 1.

Ports:
- clk  input  1  system clock; same clock as the hvsync generator.
- reset  input  1  asynchronous, active-high reset.
- hsync  input  1  horizontal sync from the generator; active-high; synchronous to clk.
- vsync  input  1  vertical sync from the generator; active-high; synchronous to clk.
- enable  input  1  when low, both outputs are held low and both channels are idle.
- pos_valid  input  1  single-cycle strobe; loads both target positions.
- pos_x  input  POS_W  X target position, in scanlines after vsync.
- pos_y  input  POS_W  Y target position, in scanlines after vsync.
- hpaddle  output  1  emulated horizontal paddle signal; registered.
- vpaddle  output  1  emulated vertical paddle signal; registered.
- cur_x  output  POS_W  active (slewed) X position; registered.
- cur_y  output  POS_W  active (slewed) Y position; registered.

Behaviour:
- Reset (async): `hpaddle`=0, `vpaddle`=0, `cur_x`=`cur_y`=0, targets=0, line_cnt=0, sync-history registers=0, both channel FSMs in IDLE.
- Edge detect: rise = input & ~registered previous value. No synchronizers are used, since the sync inputs are in the clk domain.
- Line counter (`line_cnt`, POS_W bits):
  - On vsync rise, line_cnt ← 0.
  - Otherwise, on hsync rise, line_cnt increments and saturates at 2^POS_W−1 (it does not wrap).
  - If vsync and hsync rise in the same cycle, vsync wins and line_cnt ← 0.
- Target registers:
  - On pos_valid, tgt_x ← pos_x and tgt_y ← pos_y.
  - A load coinciding with a vsync rise is stored, but the slew step in that same cycle uses the previous target.
- Slew, applied on each vsync rise, per axis:
  - If |tgt − cur| ≤ SLEW, then cur ← tgt.
  - Otherwise cur moves SLEW toward tgt.
  - Arithmetic is unsigned with one extra bit, so no underflow or overflow occurs.
- Channel FSM (identical for X and Y; shown for X):
  - IDLE: output 0. A vsync rise with enable=1 → CHARGE.
  - CHARGE: output 0. When line_cnt ≥ cur_x → FIRED, and output ← 1 on the same edge.
  - FIRED: output 1. Holds until the next vsync rise → CHARGE, with output ← 0 on that edge (discharge).
  - The comparison uses the cur_x value after that frame's slew update.
- Latency: if hsync is first sampled high at edge N and this makes line_cnt equal cur_x, line_cnt updates at edge N and `hpaddle` rises at edge N+1.
- Position 0: the output rises 1 clk after the vsync-rise edge, so the reader sees `vpos[7:0]`=0.
- Positions beyond the frame: if a frame has fewer lines than the position, the output stays low for the whole frame. The next vsync rise restarts CHARGE.
- Enable:
  - enable=0 forces both FSMs to IDLE and both outputs to 0 on the next edge.
  - After enable returns high, the channels re-arm at the next vsync rise, never mid-frame.
  - Slew continues while disabled.
- Reset mid-frame: outputs drop immediately. Channels stay IDLE until the first vsync rise after reset deasserts.
- Outputs change at most once per frame each: exactly one rising edge per frame when the position is reachable.

Test Plan:
- Steady position: pos_x=40, pos_y=100 loaded, slew settled → `hpaddle` rises 1 clk after line_cnt becomes 40 and `vpaddle` after line 100; each falls at the next vsync rise; one pulse per frame.
- Slew: cur_x=10, load pos_x=30 with SLEW=4 → cur_x reads 14, 18, 22, 26, 30 on successive vsync rises and then holds; the firing line tracks cur_x each frame.
- Edge values: pos_x=0 → `hpaddle` high 1 clk after the vsync-rise edge. pos_x=255 with a 262-line frame → fires at line 255. pos_x=255 with a 200-line frame → stays low all frame.
- Simultaneous hsync and vsync rise → line_cnt=0, channels re-enter CHARGE, no increment. A pos_valid in that same cycle is applied only at the following vsync.
- enable dropped mid-frame → both outputs 0 next clk. Raised mid-frame → outputs remain 0 until after the next vsync rise, then fire normally.
- Reset asserted while `hpaddle`=1 → `hpaddle`=0 asynchronously and cur_x=0. After release, there is no pulse until a vsync rise, and the next frame fires at line 0 (slewing from 0 toward the target).
